// File: rtl/de10_bus_resp_controller.sv
// -----------------------------------------------------------------------------
// de10_bus_resp_controller
// Return-path controller for the DE10-Lite CPU data bus. Takes one CPU request
// at a time, steers it to SDRAM or the peripheral bus by address tag, holds the
// target request until it acknowledges, and hands the result back through a
// valid/ready response handshake. A target that never acknowledges is turned
// into a bus-error response after TIMEOUT_CYCLES wait cycles (0 = never).
// -----------------------------------------------------------------------------
module de10_bus_resp_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned TAG_MSB        = 31,
    parameter int unsigned TAG_LSB        = 22
) (
    input  logic        clk,
    input  logic        rst_n,

    // CPU request channel
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,

    // CPU response channel
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,

    // Shared target request fields
    output logic [31:0] tgt_addr,
    output logic        tgt_we,
    output logic [31:0] tgt_wdata,

    // SDRAM target
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic [31:0] sdram_rdata,

    // Peripheral target
    output logic        periph_req,
    input  logic        periph_ack,
    input  logic [31:0] periph_rdata
);

    // Counter wide enough to hold TIMEOUT_CYCLES; keep one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_SDRAM  = 2'd1,
        ST_WAIT_PERIPH = 2'd2,
        ST_RESP        = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [31:0]       tgt_addr_q,   tgt_addr_d;
    logic              tgt_we_q,     tgt_we_d;
    logic [31:0]       tgt_wdata_q,  tgt_wdata_d;
    logic              sdram_req_q,  sdram_req_d;
    logic              periph_req_q, periph_req_d;
    logic [31:0]       rsp_rdata_q,  rsp_rdata_d;
    logic              rsp_err_q,    rsp_err_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;

    // Helper signals for the wait states
    logic              req_is_sdram;
    logic              sel_ack;
    logic [31:0]       sel_rdata;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    // Address decode: an all-zero tag field selects SDRAM, anything else the peripherals.
    always_comb begin
        req_is_sdram = (cpu_addr[TAG_MSB:TAG_LSB] == '0);
    end

    // Pick the ack/data of the target actually being waited on; the other one is ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = 32'h0;
        if (state_q == ST_WAIT_SDRAM) begin
            sel_ack   = sdram_ack;
            sel_rdata = sdram_rdata;
        end else if (state_q == ST_WAIT_PERIPH) begin
            sel_ack   = periph_ack;
            sel_rdata = periph_rdata;
        end
    end

    // Saturating wait counter increment and timeout detection (counter reaching the limit).
    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);
    end

    // Next-state and next-register logic; every register holds unless changed below.
    always_comb begin
        state_d      = state_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_we_d     = tgt_we_q;
        tgt_wdata_d  = tgt_wdata_q;
        sdram_req_d  = sdram_req_q;
        periph_req_d = periph_req_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    tgt_addr_d  = cpu_addr;
                    tgt_we_d    = cpu_we;
                    tgt_wdata_d = cpu_wdata;
                    cnt_d       = '0;
                    if (req_is_sdram) begin
                        state_d     = ST_WAIT_SDRAM;
                        sdram_req_d = 1'b1;
                    end else begin
                        state_d      = ST_WAIT_PERIPH;
                        periph_req_d = 1'b1;
                    end
                end
            end

            ST_WAIT_SDRAM, ST_WAIT_PERIPH: begin
                cnt_d = cnt_inc;
                // An ack in the timeout cycle still counts as a good completion.
                if (sel_ack) begin
                    rsp_rdata_d  = tgt_we_q ? 32'h0 : sel_rdata;
                    rsp_err_d    = 1'b0;
                    sdram_req_d  = 1'b0;
                    periph_req_d = 1'b0;
                    state_d      = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d  = 32'h0;
                    rsp_err_d    = 1'b1;
                    sdram_req_d  = 1'b0;
                    periph_req_d = 1'b0;
                    state_d      = ST_RESP;
                end
            end

            ST_RESP: begin
                // Hold data/err until the CPU takes them, then tidy up for the next request.
                if (cpu_rsp_ready) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                sdram_req_d  = 1'b0;
                periph_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tgt_addr_q   <= 32'h0;
            tgt_we_q     <= 1'b0;
            tgt_wdata_q  <= 32'h0;
            sdram_req_q  <= 1'b0;
            periph_req_q <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_we_q     <= tgt_we_d;
            tgt_wdata_q  <= tgt_wdata_d;
            sdram_req_q  <= sdram_req_d;
            periph_req_q <= periph_req_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        cpu_req_ready = (state_q == ST_IDLE);
        cpu_rsp_valid = (state_q == ST_RESP);
    end

    // Remaining outputs come directly from registers.
    always_comb begin
        cpu_rsp_rdata = rsp_rdata_q;
        cpu_rsp_err   = rsp_err_q;
        tgt_addr      = tgt_addr_q;
        tgt_we        = tgt_we_q;
        tgt_wdata     = tgt_wdata_q;
        sdram_req     = sdram_req_q;
        periph_req    = periph_req_q;
    end

endmodule

// File: tb/tb_de10_bus_resp_controller.sv
// -----------------------------------------------------------------------------
// Testbench for de10_bus_resp_controller (TIMEOUT_CYCLES = 8).
// Directed scenarios followed by randomized transactions. Expected behaviour of
// each transaction is derived from a cycle-level description: which target is
// requested, for how many cycles, and what response comes back when.
// -----------------------------------------------------------------------------
module tb_de10_bus_resp_controller;

    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [31:0] cpu_rsp_rdata;
    logic        cpu_rsp_err;
    logic [31:0] tgt_addr;
    logic        tgt_we;
    logic [31:0] tgt_wdata;
    logic        sdram_req;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic        periph_req;
    logic        periph_ack;
    logic [31:0] periph_rdata;

    int checks = 0;
    int errors = 0;

    de10_bus_resp_controller #(
        .TIMEOUT_CYCLES(T),
        .TAG_MSB(31),
        .TAG_LSB(22)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_addr(cpu_addr),
        .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_err(cpu_rsp_err),
        .tgt_addr(tgt_addr),
        .tgt_we(tgt_we),
        .tgt_wdata(tgt_wdata),
        .sdram_req(sdram_req),
        .sdram_ack(sdram_ack),
        .sdram_rdata(sdram_rdata),
        .periph_req(periph_req),
        .periph_ack(periph_ack),
        .periph_rdata(periph_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU transaction. ack_at = cycle of the target ack (cycle 0 = accept);
    // any value above T means the target never answers in time.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] ack_rdata,
                           input int stall, input bit noise);
        bit          to_sdram;
        bit          timed_out;
        int          last;
        logic [31:0] exp_rdata;
        logic        exp_err;

        // Reference: decode and response computed from the rules directly.
        to_sdram  = ((addr >> 22) == 0);
        timed_out = (ack_at > T);
        last      = timed_out ? T : ack_at;
        exp_err   = timed_out;
        exp_rdata = (timed_out || we) ? 32'h0 : ack_rdata;

        chk("idle_req_ready", {31'h0, cpu_req_ready}, 32'h1);
        cpu_req_valid = 1'b1;
        cpu_addr      = addr;
        cpu_we        = we;
        cpu_wdata     = wdata;
        step();                                   // cycle 0 edge: accept
        cpu_req_valid = 1'b0;
        cpu_addr      = $urandom;
        cpu_we        = 1'($urandom_range(0, 1));
        cpu_wdata     = $urandom;

        for (int c = 1; c <= last; c++) begin
            chk("wait_sdram_req",  {31'h0, sdram_req},     {31'h0, to_sdram});
            chk("wait_periph_req", {31'h0, periph_req},    {31'h0, !to_sdram});
            chk("wait_rsp_valid",  {31'h0, cpu_rsp_valid}, 32'h0);
            chk("wait_req_ready",  {31'h0, cpu_req_ready}, 32'h0);
            chk("wait_tgt_addr",   tgt_addr,  addr);
            chk("wait_tgt_we",     {31'h0, tgt_we}, {31'h0, we});
            chk("wait_tgt_wdata",  tgt_wdata, wdata);
            if (noise && ($urandom_range(0, 2) == 0)) begin
                // Ack on the target that was not asked must be ignored.
                if (to_sdram) begin periph_ack = 1'b1; periph_rdata = $urandom; end
                else          begin sdram_ack  = 1'b1; sdram_rdata  = $urandom; end
            end
            if (c == ack_at) begin
                if (to_sdram) begin sdram_ack  = 1'b1; sdram_rdata  = ack_rdata; end
                else          begin periph_ack = 1'b1; periph_rdata = ack_rdata; end
            end
            step();
            sdram_ack    = 1'b0;
            periph_ack   = 1'b0;
            sdram_rdata  = $urandom;
            periph_rdata = $urandom;
        end

        for (int s = 0; s <= stall; s++) begin
            chk("rsp_valid",      {31'h0, cpu_rsp_valid}, 32'h1);
            chk("rsp_rdata",      cpu_rsp_rdata, exp_rdata);
            chk("rsp_err",        {31'h0, cpu_rsp_err}, {31'h0, exp_err});
            chk("rsp_req_ready",  {31'h0, cpu_req_ready}, 32'h0);
            chk("rsp_sdram_req",  {31'h0, sdram_req}, 32'h0);
            chk("rsp_periph_req", {31'h0, periph_req}, 32'h0);
            if (s < stall) begin
                if (noise) begin
                    sdram_ack  = 1'($urandom_range(0, 1));
                    periph_ack = 1'($urandom_range(0, 1));
                end
                step();
                sdram_ack  = 1'b0;
                periph_ack = 1'b0;
            end else begin
                cpu_rsp_ready = 1'b1;
                step();
                cpu_rsp_ready = 1'b0;
            end
        end

        chk("post_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
        chk("post_req_ready", {31'h0, cpu_req_ready}, 32'h1);
        chk("post_rdata",     cpu_rsp_rdata, 32'h0);
        chk("post_err",       {31'h0, cpu_rsp_err}, 32'h0);

        if (timed_out) begin
            // A late ack after the timeout must not create a second response.
            if (to_sdram) sdram_ack = 1'b1; else periph_ack = 1'b1;
            step();
            sdram_ack  = 1'b0;
            periph_ack = 1'b0;
            chk("late_ack_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
            chk("late_ack_req_ready", {31'h0, cpu_req_ready}, 32'h1);
        end
    endtask

    initial begin
        logic [31:0] r_addr;
        rst_n         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_addr      = 32'h0;
        cpu_we        = 1'b0;
        cpu_wdata     = 32'h0;
        cpu_rsp_ready = 1'b0;
        sdram_ack     = 1'b0;
        sdram_rdata   = 32'h0;
        periph_ack    = 1'b0;
        periph_rdata  = 32'h0;

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_req_ready",  {31'h0, cpu_req_ready}, 32'h1);
        chk("reset_rsp_valid",  {31'h0, cpu_rsp_valid}, 32'h0);
        chk("reset_sdram_req",  {31'h0, sdram_req}, 32'h0);
        chk("reset_periph_req", {31'h0, periph_req}, 32'h0);
        chk("reset_tgt_addr",   tgt_addr, 32'h0);
        chk("reset_rdata",      cpu_rsp_rdata, 32'h0);
        chk("reset_err",        {31'h0, cpu_rsp_err}, 32'h0);

        // Reset in the middle of an SDRAM wait
        cpu_req_valid = 1'b1;
        cpu_addr      = 32'h0000_0100;
        step();
        cpu_req_valid = 1'b0;
        step();
        chk("pre_rst_sdram_req", {31'h0, sdram_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_sdram_req", {31'h0, sdram_req}, 32'h0);
        chk("async_rst_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
        chk("async_rst_req_ready", {31'h0, cpu_req_ready}, 32'h1);
        step();
        rst_n = 1'b1;
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_rsp_valid", {31'h0, cpu_rsp_valid}, 32'h0);
            chk("post_rst_sdram_req", {31'h0, sdram_req}, 32'h0);
            step();
        end

        // Directed scenarios
        run_txn(32'h0000_1000, 1'b0, 32'h0,         1,   32'hCAFE_F00D, 0, 1'b0); // min-latency SDRAM read
        run_txn(32'h0040_0000, 1'b1, 32'h1234_5678, 4,   32'hDEAD_BEEF, 0, 1'b0); // peripheral write
        run_txn(32'h0080_0010, 1'b0, 32'h0,         100, 32'h0,         0, 1'b0); // timeout
        run_txn(32'h0000_2000, 1'b0, 32'h0,         100, 32'h0,         2, 1'b1); // SDRAM timeout, acks in RESP
        run_txn(32'h00C0_0004, 1'b0, 32'h0,         T,   32'h5A5A_A5A5, 0, 1'b0); // ack on timeout cycle
        run_txn(32'h0000_3000, 1'b0, 32'h0,         T,   32'h0BAD_CAFE, 0, 1'b1); // same, SDRAM side
        run_txn(32'h0000_0040, 1'b0, 32'h0,         2,   32'h1357_9BDF, 5, 1'b0); // backpressure

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr = r_addr & 32'h003F_FFFF;
            else if ((r_addr >> 22) == 0)  r_addr = r_addr | 32'h0040_0000;
            run_txn(r_addr, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(1, T + 3), $urandom,
                    $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
